// File: rtl/sha_pkg.sv
// Shared constants, state type and byte-placement helpers for the SHA message padder.
package sha_pkg;

  localparam int BLOCK_W         = 512;
  localparam int LEN_W           = 64;
  localparam int BYTES_PER_BLOCK = 64;
  localparam int LEN_OFFSET      = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    FILL,
    OUT_DATA,
    OUT_PEND,
    OUT_LEN,
    OUT_FINAL
  } padder_state_e;

  // Write one byte into a block at byte index idx; byte 0 is the most significant byte.
  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [5:0]         idx,
                                                   input logic [7:0]         val);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[BLOCK_W-1-8*int'(idx) -: 8] = val;
    return r;
  endfunction

  // Message length in bits as the 64-bit big-endian trailer of the last block.
  function automatic logic [LEN_W-1:0] len_field(input logic [31:0] len_bytes);
    return {29'b0, len_bytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha_msg_padder_if.sv
// Byte-in / block-out bundle between a byte source, the padder and a SHA core.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1;
// the sender holds data/last stable while valid=1 and ready=0, the receiver may
// change ready freely, and valid never waits on ready.
interface sha_msg_padder_if;
  import sha_pkg::*;

  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               out_valid;
  logic               out_last;
  logic               out_ready;
  padder_state_e      state;

  // Byte source and block sink side.
  modport master (
    output in_byte, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_valid, out_last, state
  );

  // Padder side.
  modport slave (
    input  in_byte, in_valid, in_last, out_ready,
    output in_ready, out_block, out_valid, out_last, state
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA message padder: packs bytes into 512-bit blocks, appends the 0x80 marker,
// zero fill and the 64-bit bit-length trailer, and emits the blocks in order.
module sha_msg_padder
  import sha_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sha_msg_padder_if.slave  bus
);

  localparam logic [6:0] BLOCK_BYTES = 7'(BYTES_PER_BLOCK);
  localparam logic [6:0] LAST_INLINE = 7'(LEN_OFFSET - 1);

  padder_state_e      state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [6:0]         idx_q, idx_d;
  logic [31:0]        len_q, len_d;
  logic               last_q, last_d;
  logic               defer_q, defer_d;

  logic [6:0]         idx_inc;
  logic [31:0]        len_inc;

  // Input is only taken while filling and output only offered while emitting,
  // so the two sides can never transfer in the same cycle.
  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q != FILL);
  assign bus.out_block = blk_q;
  assign bus.out_last  = last_q;
  assign bus.state     = state_q;

  assign idx_inc = idx_q + 7'd1;
  assign len_inc = len_q + 32'd1;

  // Next-state logic: byte packing, padding decisions and block hand-off.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    len_d   = len_q;
    last_d  = last_q;
    defer_d = defer_q;
    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          blk_d = put_byte(blk_q, idx_q[5:0], bus.in_byte);
          idx_d = idx_inc;
          len_d = len_inc;
          if (!bus.in_last) begin
            if (idx_inc == BLOCK_BYTES) begin
              state_d = OUT_DATA;
              last_d  = 1'b0;
            end
          end else if (idx_inc <= LAST_INLINE) begin
            // Marker and trailer both fit: this is the only block left.
            blk_d        = put_byte(blk_d, idx_inc[5:0], PAD_BYTE);
            blk_d[63:0]  = len_field(len_inc);
            state_d      = OUT_FINAL;
            last_d       = 1'b1;
          end else if (idx_inc < BLOCK_BYTES) begin
            // Marker fits but the trailer needs one more block.
            blk_d   = put_byte(blk_d, idx_inc[5:0], PAD_BYTE);
            state_d = OUT_PEND;
            last_d  = 1'b0;
            defer_d = 1'b0;
          end else begin
            // Block is full of data; the marker moves to the next block.
            state_d = OUT_PEND;
            last_d  = 1'b0;
            defer_d = 1'b1;
          end
        end
      end
      OUT_DATA: begin
        if (bus.out_ready) begin
          state_d = FILL;
          blk_d   = '0;
          idx_d   = '0;
        end
      end
      OUT_PEND: begin
        if (bus.out_ready) begin
          blk_d = '0;
          if (defer_q) begin
            blk_d[BLOCK_W-1 -: 8] = PAD_BYTE;
          end
          blk_d[63:0] = len_field(len_q);
          state_d     = OUT_LEN;
          last_d      = 1'b1;
          defer_d     = 1'b0;
        end
      end
      OUT_LEN, OUT_FINAL: begin
        if (bus.out_ready) begin
          state_d = FILL;
          blk_d   = '0;
          idx_d   = '0;
          len_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = FILL;
        blk_d   = '0;
        idx_d   = '0;
        len_d   = '0;
        last_d  = 1'b0;
        defer_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      defer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      last_q  <= last_d;
      defer_q <= defer_d;
    end
  end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: directed padding cases, backpressure, mid-message
// reset and random messages against a byte-level SHA padding model.
module tb_sha_msg_padder;
  import sha_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_msg_padder_if bus();

  sha_msg_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard
  logic [511:0] exp_q[$];
  logic         exp_last_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: standard SHA padding of the whole message, then cut into 64-byte blocks.
  task automatic model_pad(input logic [7:0] msg[$]);
    logic [7:0]   q[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int nblk;
    q = msg;
    bits = 64'(msg.size()) * 64'd8;
    q.push_back(8'h80);
    while ((q.size() % 64) != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(bits[8*i +: 8]);
    nblk = q.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*b + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic last);
    int gap;
    int t;
    logic acc;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_byte  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_last  = last;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL in_accept_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$]);
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_out_valid", 512'(bus.out_valid), 512'd0);
    chk("rst_out_last",  512'(bus.out_last),  512'd0);
    chk("rst_out_block", bus.out_block,       512'd0);
    chk("rst_in_ready",  512'(bus.in_ready),  512'd1);
    chk("rst_state",     512'(bus.state),     512'(FILL));
  endtask

  // Downstream ready generator
  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       bus.out_ready = ($urandom_range(0, 3) != 0);
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Compare process: interlock, hold stability and every accepted block.
  logic         hold_prev = 1'b0;
  logic [511:0] hold_blk;
  logic         hold_last;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("in_ready_interlock", 512'(bus.in_ready), 512'(!bus.out_valid));
      if (hold_prev) begin
        chk("hold_valid", 512'(bus.out_valid), 512'd1);
        chk("hold_block", bus.out_block, hold_blk);
        chk("hold_last",  512'(bus.out_last), 512'(hold_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_block: got %0h expected no block", bus.out_block);
        end else begin
          chk("out_block", bus.out_block, exp_q.pop_front());
          chk("out_last",  512'(bus.out_last), 512'(exp_last_q.pop_front()));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_blk  = bus.out_block;
      hold_last = bus.out_last;
    end
  end

  // Stimulus
  logic [7:0]   msg[$];
  logic [7:0]   abc[$];
  logic [511:0] abc_lit;
  logic [511:0] cap_blk;
  int lens[$];
  int t;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_byte  = 8'h00;
    abc = '{8'h61, 8'h62, 8'h63};
    abc_lit = {32'h61626380, 416'b0, 64'h18};
    repeat (3) @(posedge clk);
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    // "abc": single final block
    model_pad(abc);
    chk("pin_abc", exp_q[0], abc_lit);
    send_msg(abc);
    wait_drain();

    // 56 bytes: marker inline, trailer in second block
    msg.delete();
    repeat (56) msg.push_back(8'h61);
    model_pad(msg);
    chk("pin_56_b1", exp_q[0], {{56{8'h61}}, 8'h80, 56'h0});
    chk("pin_56_l1", 512'(exp_last_q[0]), 512'd0);
    chk("pin_56_b2", exp_q[1], {448'b0, 64'h1C0});
    send_msg(msg);
    wait_drain();

    // 64 bytes: marker deferred
    msg.delete();
    repeat (64) msg.push_back(8'h61);
    model_pad(msg);
    chk("pin_64_b1", exp_q[0], {64{8'h61}});
    chk("pin_64_b2", exp_q[1], {8'h80, 440'b0, 64'h200});
    chk("pin_64_l2", 512'(exp_last_q[1]), 512'd1);
    send_msg(msg);
    wait_drain();

    // 65 bytes: data block, then tail with marker and trailer
    msg.delete();
    repeat (65) msg.push_back(8'h61);
    model_pad(msg);
    chk("pin_65_b2", exp_q[1], {8'h61, 8'h80, 432'b0, 64'h208});
    send_msg(msg);
    wait_drain();

    // Backpressure: block held for 5 cycles with out_ready low
    ready_mode = 2;
    model_pad(abc);
    send_msg(abc);
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", 512'(bus.out_valid), 512'd1);
    cap_blk = bus.out_block;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 512'(bus.out_valid), 512'd1);
      chk("bp_block", bus.out_block, cap_blk);
      chk("bp_in_ready", 512'(bus.in_ready), 512'd0);
    end
    @(posedge clk); #1;
    ready_mode = 1;
    wait_drain();

    // Reset mid-message, then "abc" must come out clean
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;
    model_pad(abc);
    chk("pin_abc_after_rst", exp_q[0], abc_lit);
    send_msg(abc);
    wait_drain();

    // Random messages including padding boundary lengths, random backpressure
    ready_mode = 0;
    lens = '{1, 55, 56, 57, 63, 64, 119, 120, 127, 128};
    repeat (12) lens.push_back($urandom_range(1, 140));
    foreach (lens[k]) begin
      msg.delete();
      for (int i = 0; i < lens[k]; i++) msg.push_back(8'($urandom));
      model_pad(msg);
      send_msg(msg);
      wait_drain();
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha_msg_padder.md
SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

Interface
REQ-001 The block SHALL have parameters: none; all widths are fixed in sha_pkg.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_byte  input  8  next message byte.
REQ-005 The block SHALL have port in_valid  input  1  in_byte is valid.
REQ-006 The block SHALL have port in_last  input  1  qualifies in_valid; the byte is the final byte of the message.
REQ-007 The block SHALL have port in_ready  output  1  a byte is accepted on in_valid && in_ready.
REQ-008 The block SHALL have port out_block  output  512  padded block, byte 0 in [511:504] (big-endian).
REQ-009 The block SHALL have port out_valid  output  1  out_block is valid.
REQ-010 The block SHALL have port out_last  output  1  qualifies out_valid; the block is the final block of the message.
REQ-011 The block SHALL have port out_ready  input  1  the downstream SHA core accepts on out_valid && out_ready.

Function
REQ-012 The block SHALL implement states FILL, OUT_DATA, OUT_PEND, OUT_LEN and OUT_FINAL.
REQ-013 in_ready SHALL be 1 only in FILL, and out_valid SHALL be 1 only in the OUT_* states, so input and output never transfer in the same cycle.
REQ-014 In FILL, each accepted byte SHALL be written at block index idx (0..63), idx SHALL increment, and a 32-bit byte counter msg_len SHALL increment modulo 2^32.
REQ-015 Let n = idx after an accepted byte; if in_last=0 and n=64, the state SHALL go to OUT_DATA with out_last=0.
REQ-016 If in_last=1 and n<=55, the block SHALL get 0x80 at byte n, zeros through byte 55, and the length field in bytes 56..63; the state SHALL go to OUT_FINAL with out_last=1.
REQ-017 If in_last=1 and 56<=n<=63, the block SHALL get 0x80 at byte n and zeros after it; the state SHALL go to OUT_PEND with out_last=0.
REQ-018 If in_last=1 and n=64, the block SHALL be emitted as data; the state SHALL go to OUT_PEND with out_last=0, and the 0x80 marker SHALL be deferred.
REQ-019 Length field SHALL be 64-bit big-endian, value = {29'b0, msg_len, 3'b000} in bits, taken from msg_len including the final byte.
REQ-020 From OUT_DATA, on handshake the block SHALL go to FILL, clear the buffer and idx, and keep msg_len.
REQ-021 From OUT_PEND, on handshake the block SHALL go to OUT_LEN with an all-zero block plus length field, with 0x80 at byte 0 if the marker was deferred, and out_last=1.
REQ-022 From OUT_LEN or OUT_FINAL, on handshake the block SHALL go to FILL and clear the buffer, idx and msg_len.
REQ-023 out_block and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 in_last while in_valid=0 SHALL be ignored; zero-length messages are not supported.
REQ-025 A message longer than 2^32-1 bytes SHALL wrap msg_len silently, which produces a wrong length field by definition.

Reset
REQ-026 rst=1 at a rising clk edge SHALL force state FILL, idx=0, msg_len=0, buffer=0, out_valid=0, out_last=0, out_block=0, in_ready=1 in the following cycle.
REQ-027 rst SHALL take priority over any handshake in the same cycle, and a partial message SHALL be discarded with no block emitted.

Structure
REQ-028 sha_pkg SHALL hold BLOCK_W=512, LEN_W=64, BYTES_PER_BLOCK=64, LEN_OFFSET=56, PAD_BYTE=8'h80 and the padder state enum.
REQ-029 The design SHALL be a single module with no sub-module; out_block SHALL be driven directly from the block register.

Verification
REQ-030 Bench SHALL drive "abc" (61,62,63, last) -> one block 0x61626380 followed by zeros, with final 64 bits 0x18 and out_last=1.
REQ-031 Bench SHALL drive 56 bytes 0x61 -> block 1 = 56x61, 80, 7x00 with out_last=0; block 2 = zeros with length 0x1C0 and out_last=1.
REQ-032 Bench SHALL drive 64 bytes 0x61 -> block 1 = all 0x61 with out_last=0; block 2 = 80, zeros, length 0x200 with out_last=1.
REQ-033 Bench SHALL drive 65 bytes 0x61 -> block 1 = all 0x61; block 2 = 61, 80, zeros, length 0x208 with out_last=1.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles on a pending block -> out_valid held, out_block unchanged, in_ready=0 throughout.
REQ-035 Bench SHALL assert rst after 10 bytes of a message, then drive "abc" -> output identical to REQ-030 with no stale bytes.
